// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one start bit, 5-8 data bits (LSB first),
// optional even/odd parity and 1 or 2 stop bits. state_dbg encodes IDLE=0,
// START=1, DATA=2, PARITY=3, STOP=4.
module uart_tx_engine #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_tx_i,
  input  logic [31:0] tx_data_i,
  input  logic [1:0]  data_bit_num_i,
  input  logic        stop_bit_num_i,
  input  logic        parity_en_i,
  input  logic        parity_type_i,
  output logic        tx_o,
  output logic        tx_done_o,
  output logic [2:0]  state_dbg
);

  // Handshake: start_tx_i is a request level sampled only while IDLE; the
  // engine leaves IDLE on the accepting edge and drops tx_done_o with it, so
  // a one-cycle level suffices and a held level cannot be taken twice in one
  // frame. tx_done_o returns high on the edge that re-enters IDLE.

  localparam int unsigned CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      data_q;
  logic [1:0]      nbits_q;
  logic            par_en_q;
  logic            par_type_q;
  logic            stop2_q;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            latch_cfg;
  logic            bit_end;
  logic [2:0]      last_data_idx;
  logic [7:0]      data_mask;
  logic            parity_bit;
  logic            unused_data_hi;

  assign unused_data_hi = ^tx_data_i[31:8];

  assign bit_end       = (cnt_q == CNT_MAX);
  // Data width N = 5 + nbits, so the last index N-1 is 4 + nbits.
  assign last_data_idx = {1'b1, nbits_q};

  always_comb begin
    data_mask = 8'hFF;
    case (nbits_q)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  // Bits above N-1 are masked off so they never reach the parity.
  assign parity_bit = (^(data_q & data_mask)) ^ par_type_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    latch_cfg = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (start_tx_i) begin
          latch_cfg = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == last_data_idx) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == {2'b00, stop2_q}) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Line and done are registered from the next state, so they move only on
  // bit boundaries and line up with the state they describe.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[idx_d];
      PARITY:  tx_d = parity_bit;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
    end else if (latch_cfg) begin
      data_q     <= tx_data_i[7:0];
      nbits_q    <= data_bit_num_i;
      par_en_q   <= parity_en_i;
      par_type_q <= parity_type_i;
      stop2_q    <= stop_bit_num_i;
    end
  end

  assign tx_o      = tx_q;
  assign tx_done_o = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at BAUD_DIV = 4: frame shapes, lengths,
// back-to-back start, mid-frame config changes and asynchronous reset.
module tb_uart_tx_engine;

  localparam int BD = 4;

  logic        clk;
  logic        reset;
  logic        start_tx_i;
  logic [31:0] tx_data_i;
  logic [1:0]  data_bit_num_i;
  logic        stop_bit_num_i;
  logic        parity_en_i;
  logic        parity_type_i;
  logic        tx_o;
  logic        tx_done_o;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  uart_tx_engine #(.BAUD_DIV(BD)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_tx_i     (start_tx_i),
    .tx_data_i      (tx_data_i),
    .data_bit_num_i (data_bit_num_i),
    .stop_bit_num_i (stop_bit_num_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .tx_o           (tx_o),
    .tx_done_o      (tx_done_o),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a start request at a negedge; returns at the negedge following the
  // accepting posedge (frame cycle 0).
  task automatic start_frame(input logic [7:0] data, input logic [1:0] nb,
                             input logic pe, input logic pt, input logic s2,
                             input logic hold);
    @(negedge clk);
    tx_data_i      = {24'h0, data};
    data_bit_num_i = nb;
    parity_en_i    = pe;
    parity_type_i  = pt;
    stop_bit_num_i = s2;
    start_tx_i     = 1'b1;
    @(negedge clk);
    if (!hold) start_tx_i = 1'b0;
  endtask

  // bits holds the expected line in transmit order, first bit leftmost in
  // the low n bits. Returns at the negedge where tx_done_o is seen high.
  task automatic watch_frame(input string tag, input int n, input logic [15:0] bits,
                             input int low_exp, input int change_at);
    int  low  = 0;
    bit  seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (tx_done_o === 1'b1) begin
        seen = 1;
        break;
      end
      if (c / BD < n) check({tag, ".tx"}, {31'h0, tx_o}, {31'h0, bits[n - 1 - c / BD]});
      if (c == change_at) begin
        tx_data_i      = 32'h0;
        data_bit_num_i = 2'b00;
      end
      low++;
      @(negedge clk);
    end
    check({tag, ".done_seen"}, {31'h0, seen}, 32'd1);
    check({tag, ".low_len"}, low, low_exp);
    check({tag, ".end_tx"}, {31'h0, tx_o}, 32'd1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check({tag, ".tx"}, {31'h0, tx_o}, 32'd1);
      check({tag, ".done"}, {31'h0, tx_done_o}, 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    reset          = 1'b0;
    start_tx_i     = 1'b0;
    tx_data_i      = 32'h0;
    data_bit_num_i = 2'b00;
    stop_bit_num_i = 1'b0;
    parity_en_i    = 1'b0;
    parity_type_i  = 1'b0;

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst.tx", {31'h0, tx_o}, 32'd1);
    check("rst.done", {31'h0, tx_done_o}, 32'd1);
    check("rst.state", {29'h0, state_dbg}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle("rst_idle", 6);

    // 8N1 0xA5
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    watch_frame("8n1", 10, 16'b0101001011, 40, -1);
    check_idle("8n1_idle", 4);

    // 7E1 0x35
    start_frame(8'h35, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    watch_frame("7e1", 10, 16'b0101011001, 40, -1);
    check_idle("7e1_idle", 4);

    // 5O2 0xFF
    start_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    watch_frame("5o2", 9, 16'b011111011, 36, -1);
    check_idle("5o2_idle", 4);

    // start held through the frame, config changed mid-frame
    start_frame(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    watch_frame("busy1", 10, 16'b0111100001, 40, 8);
    @(negedge clk);
    check("busy.b2b_done", {31'h0, tx_done_o}, 32'd0);
    start_tx_i = 1'b0;
    watch_frame("busy2", 7, 16'b0000001, 28, -1);
    check_idle("busy_idle", 4);

    // reset during DATA bit 3 of 0xA5 (line low there)
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    check("midrst.pre_tx", {31'h0, tx_o}, 32'd0);
    check("midrst.pre_done", {31'h0, tx_done_o}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("midrst.tx", {31'h0, tx_o}, 32'd1);
    check("midrst.done", {31'h0, tx_done_o}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    check_idle("midrst_idle", 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmit stage of the APB-UART, directly downstream of the register block. It accepts a start request and the frame configuration (data width, parity enable/type, stop-bit count) from the register block, then serialises the data onto the TX line LSB first. It returns a level `tx_done_o` that feeds the TX-done status bit and the auto-clear of the start control bit.

## Interface
- `BAUD_DIV`, default 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start_tx_i` input 1: start request level from the control register; sampled only in IDLE.
- `tx_data_i` input 32: transmit data; only bits [7:0] are used.
- `data_bit_num_i` input 2: data width; 00 = 5, 01 = 6, 10 = 7, 11 = 8 bits.
- `stop_bit_num_i` input 1: 0 = one stop bit, 1 = two stop bits.
- `parity_en_i` input 1: 1 = append a parity bit.
- `parity_type_i` input 1: 0 = even, 1 = odd.
- `tx_o` output 1: serial line, registered; idles high.
- `tx_done_o` output 1: registered; 1 when IDLE and ready, 0 while a frame is in flight.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `tx_o` = 1 and `tx_done_o` = 1. When `start_tx_i` = 1 at an edge:
  - Latch `tx_data_i[7:0]`, data width N, parity enable/type and stop count S into shadow registers.
  - Clear the baud counter and go to START.
- **Config latching:** all inputs are ignored outside IDLE. Mid-frame changes to data or configuration do not affect the current frame.
- **Bit timing:** the baud counter runs 0 to BAUD_DIV−1. Each state holds for exactly BAUD_DIV cycles per bit, and the state advances when the counter reaches BAUD_DIV−1.
- **START:** `tx_o` = 0 for one bit, then go to DATA with bit index 0.
- **DATA:** `tx_o` = shadow data bit [index], LSB first.
  - After the bit with index N−1, go to PARITY if parity is enabled, otherwise go to STOP.
  - Bit index is 3 bits wide and never wraps within a frame.
- **PARITY:** send one bit.
  - Even parity: the XOR of data bits [N−1:0].
  - Odd parity: the inverse of that XOR.
  - Bits above N−1 never contribute.
- **STOP:** `tx_o` = 1 for S bits (1 or 2), then go to IDLE.
- **Return to IDLE:** `tx_done_o` rises on the same edge that enters IDLE. If `start_tx_i` is still 1 in the next cycle, a new frame starts back-to-back.
- **Reset:** asynchronous assertion at any time, including mid-frame, forces:
  - state = IDLE, `tx_o` = 1, `tx_done_o` = 1;
  - counters and shadow registers = 0.
  - No partial frame resumes after reset.
- **Reset values:** `tx_o` = 1, `tx_done_o` = 1.

## Timing
- **Acceptance:** `start_tx_i` = 1 is sampled at edge k in IDLE. Then `tx_o` = 0 and `tx_done_o` = 0 from edge k onward, with one cycle of latency.
- **Frame length:** L = (1 + N + P + S) × BAUD_DIV cycles, where P = parity enable (0 or 1).
  - `tx_o` returns to idle and `tx_done_o` = 1 at edge k + L.
- **Handshake with the register block:**
  - The register block clears `start_tx_i` one cycle after it sees `tx_done_o` = 1.
  - The engine must have left IDLE by then, so a single-cycle start level is sufficient.
  - A level held for longer is never double-accepted within one frame.
- **No glitches:** `tx_o` changes only on bit boundaries, i.e. every BAUD_DIV cycles.

## Test plan
Run with `BAUD_DIV` = 4.
- **Reset values:** assert reset → `tx_o` = 1 and `tx_done_o` = 1 immediately (asynchronous); both hold with `start_tx_i` = 0.
- **8N1:** data 0xA5, cfg 8-bit / no parity / 1 stop; pulse start.
  - `tx_o` per bit: 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `tx_done_o` low for exactly 40 cycles.
- **7E1:** data 0x35, cfg 7-bit / even / 1 stop.
  - Bits: 0,1,0,1,0,1,1,0, parity 0, stop 1.
  - `tx_done_o` low for 40 cycles.
- **5O2:** data 0xFF, cfg 5-bit / odd / 2 stop.
  - Bits: 0,1,1,1,1,1, parity 0, then 1,1.
  - `tx_done_o` low for 36 cycles; bits [7:5] are never sent.
- **Busy / mid-frame change:** start held high throughout an 8N1 frame of 0x0F. Mid-frame, change `tx_data_i` to 0x00 and `data_bit_num_i` to 00.
  - The first frame still sends 0x0F as 8 bits.
  - A second frame (0x00, 5 bits) starts the cycle after `tx_done_o` rises.
- **Reset mid-frame:** assert reset during DATA bit 3.
  - `tx_o` = 1 and `tx_done_o` = 1 asynchronously.
  - After release with `start_tx_i` = 0, the line stays idle high.
